// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side bundle of uart_rx; data/valid/ready handshake plus frame_err/overrun pulses
interface uart_rx_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  logic frame_err;
  logic overrun;
  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver; clk/rst, rx serial line in, bus = byte holding register (data/valid/ready) with frame_err/overrun pulses
module uart_rx #(
  parameter int BAUD = 115200,
  parameter int F = 50000000
) (
  input logic clk,
  input logic rst,
  input logic rx,
  uart_rx_if.master bus
);
  localparam int CPB = F / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] MID = CW'(HALF - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_nx;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic tick, mid, done, byte_ok, byte_bad;
  assign tick = cnt == LAST;
  assign mid = cnt == MID;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      cnt <= (state == IDLE || state == WAIT_HIGH || (state == START && mid) || tick) ? '0 : cnt + CW'(1);
      idx <= state == DATA ? idx + {2'b00, tick} : '0;
      if (state == DATA && tick) shreg <= {rx_s, shreg[7:1]};
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = rx_s ? IDLE : START;
      START: state_nx = mid ? (rx_s ? IDLE : DATA) : START;
      DATA: state_nx = (tick && idx == 3'd7) ? STOP : DATA;
      STOP: state_nx = tick ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_nx = rx_s ? IDLE : WAIT_HIGH;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    byte_ok = state == STOP && tick && rx_s;
    byte_bad = state == STOP && tick && !rx_s;
  end
  // shreg stays put until the next frame's first data tick, so it is safe to load one cycle after the stop tick
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      bus.data <= 8'h00;
      bus.valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      done <= byte_ok;
      bus.frame_err <= byte_bad;
      bus.overrun <= done && bus.valid && !bus.ready;
      if (done && (!bus.valid || bus.ready)) begin
        bus.data <= shreg;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) bus.valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CPB=10
module tb_uart_rx;
  localparam int CPB = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_n = 0;
  int ov_n = 0;
  int vr_n = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  int fe0, ov0, vr0, lat;
  logic v_q = 1'b0;
  logic [7:0] rxq[$];
  uart_rx_if bus();
  uart_rx #(.BAUD(100000), .F(1000000)) dut (.clk(clk), .rst(rst), .rx(rx), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) fe_n <= fe_n + 1;
      if (bus.overrun) ov_n <= ov_n + 1;
      if (bus.valid && !v_q) begin
        vr_n <= vr_n + 1;
        rise_cyc <= cyc;
      end
      if (bus.valid && bus.ready) rxq.push_back(bus.data);
    end
    v_q <= bus.valid;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      step(CPB);
    end
  endtask
  task automatic pulse_ready();
    bus.ready = 1'b1;
    step(1);
    bus.ready = 1'b0;
  endtask
  initial begin
    logic [7:0] part;
    bus.ready = 1'b0;
    step(3);
    rst = 1'b0;
    chk("rst_data", bus.data, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    step(200);
    chk("idle_valid_rises", vr_n, 0);
    chk("idle_fe_cycles", fe_n, 0);
    chk("idle_ov_cycles", ov_n, 0);
    send(8'hA5, 1'b1);
    step(3);
    lat = rise_cyc - start_cyc;
    chk("a5_valid", bus.valid, 1'b1);
    chk("a5_data", bus.data, 8'hA5);
    chk("a5_latency_in_96_100", lat >= 96 && lat <= 100, 1'b1);
    pulse_ready();
    chk("a5_valid_cleared", bus.valid, 1'b0);
    rxq.delete();
    fe0 = fe_n;
    ov0 = ov_n;
    bus.ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i & 7), 1'b1);
    step(5);
    bus.ready = 1'b0;
    chk("loop_count", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++) chk($sformatf("loop_byte%0d", i), rxq[i], i & 7);
    chk("loop_no_fe", fe_n, fe0);
    chk("loop_no_ov", ov_n, ov0);
    vr0 = vr_n;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(30);
    chk("glitch_no_valid", vr_n, vr0);
    chk("glitch_no_fe", fe_n, fe0);
    send(8'h3C, 1'b1);
    step(3);
    chk("3c_valid", bus.valid, 1'b1);
    chk("3c_data", bus.data, 8'h3C);
    pulse_ready();
    vr0 = vr_n;
    send(8'h81, 1'b0);
    rx = 1'b0;
    step(30);
    rx = 1'b1;
    step(20);
    chk("81_fe_one_cycle", fe_n, fe0 + 1);
    chk("81_no_valid", vr_n, vr0);
    chk("81_valid_low", bus.valid, 1'b0);
    send(8'h7E, 1'b1);
    step(3);
    chk("7e_valid", bus.valid, 1'b1);
    chk("7e_data", bus.data, 8'h7E);
    chk("7e_no_fe", fe_n, fe0 + 1);
    pulse_ready();
    vr0 = vr_n;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    step(3);
    chk("ovr_data_kept", bus.data, 8'h11);
    chk("ovr_valid", bus.valid, 1'b1);
    chk("ovr_pulse_once", ov_n, ov0 + 1);
    chk("ovr_one_rise", vr_n, vr0 + 1);
    pulse_ready();
    fe0 = fe_n;
    vr0 = vr_n;
    part = 8'h5A;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 5; i++) begin
      rx = part[i];
      step(i == 4 ? 5 : CPB);
    end
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    rx = 1'b1;
    step(30);
    chk("mrst_valid", bus.valid, 1'b0);
    chk("mrst_data", bus.data, 8'h00);
    chk("mrst_no_fe", fe_n, fe0);
    chk("mrst_no_rise", vr_n, vr0);
    send(8'hC3, 1'b1);
    step(3);
    chk("c3_valid", bus.valid, 1'b1);
    chk("c3_data", bus.data, 8'hC3);
    chk("c3_no_fe", fe_n, fe0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
